// File: rtl/de_coder_config_seq.sv
// -----------------------------------------------------------------------------
// de_coder_config_seq
//
// Walks a register table held in an external synchronous ROM and hands each
// entry to the downstream video-decoder I2C register writer. An entry whose
// sub-address is 8'hFF is a delay entry: it waits data*256 cycles and issues
// no write. A failed write attempt is retried up to MAX_RETRY times. The
// sequence stops in DONE when every entry has completed, or in FAIL with the
// failing index when an entry runs out of retries.
//
// Parameters
//   N_REGS      number of table entries (indices 0..N_REGS-1)
//   ADDR_W      rom_addr_o width, 2**ADDR_W >= N_REGS
//   MAX_RETRY   re-issues allowed per entry after a failed attempt
//   TIMEOUT     cycles allowed in each handshake wait state (>= 1)
//   GAP_CYCLES  idle cycles after every completed attempt
//
// Ports
//   clk_i        clock, shared with the downstream writer
//   rst_i        asynchronous, active-high reset
//   start_i      level-sampled; starts a sequence at index 0 when not busy
//   rom_addr_o   table index (registered)
//   rom_data_i   {subaddr[15:8], data[7:0]}, valid one cycle after rom_addr_o
//   sub_addr_l_o sub-address to the writer (registered)
//   data_o       register data to the writer (registered)
//   write_o      one-cycle write request to the writer
//   ready_i      writer idle/complete indication
//   errory_i     writer error flag, sampled when ready_i rises
//   busy_o       sequence in progress
//   done_o       level: all entries completed
//   fail_o       level: an entry exhausted its retries
//   err_index_o  index of the failing entry, valid while fail_o is high
// -----------------------------------------------------------------------------
module de_coder_config_seq #(
   parameter int N_REGS     = 64,
   parameter int ADDR_W     = 6,
   parameter int MAX_RETRY  = 3,
   parameter int TIMEOUT    = 4095,
   parameter int GAP_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [15:0]       rom_data_i,
   output logic [7:0]        sub_addr_l_o,
   output logic [7:0]        data_o,
   output logic              write_o,
   input  logic              ready_i,
   input  logic              errory_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] err_index_o
);

   localparam int RETRY_W = (MAX_RETRY  > 0) ? $clog2(MAX_RETRY + 1)  : 1;
   localparam int TO_W    = (TIMEOUT    > 0) ? $clog2(TIMEOUT + 1)    : 1;
   localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_REGS - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   // Wait and gap counters hold "cycles remaining after this one", so a load
   // of N-1 keeps the state for exactly N cycles.
   localparam logic [TO_W-1:0]    TO_LOAD   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [7:0]         DELAY_TAG = 8'hFF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_DELAY,
      S_GAP,
      S_DONE,
      S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [7:0]          sub_addr_q, sub_addr_d;
   logic [7:0]          data_q, data_d;
   logic                write_q, write_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fail_q, fail_d;
   logic [ADDR_W-1:0]   err_index_q, err_index_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [15:0]         dly_q, dly_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                gap_to_issue_q, gap_to_issue_d;  // GAP exits to ISSUE (retry) vs FETCH

   logic attempt_ok;
   logic attempt_err;

   always_comb begin
      // NOTE: every signal written here gets its default first; a path that
      // leaves one unassigned would infer a latch.
      state_d        = state_q;
      rom_addr_d     = rom_addr_q;
      sub_addr_d     = sub_addr_q;
      data_d         = data_q;
      err_index_d    = err_index_q;
      retry_d        = retry_q;
      to_d           = to_q;
      dly_d          = dly_q;
      gap_d          = gap_q;
      gap_to_issue_d = gap_to_issue_q;
      attempt_ok     = 1'b0;
      attempt_err    = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start_i) begin
               state_d     = S_FETCH;
               rom_addr_d  = '0;
               retry_d     = '0;
               err_index_d = '0;
            end
         end

         // ROM latency cycle: rom_data_i follows rom_addr_o one edge later.
         S_FETCH: state_d = S_LATCH;

         S_LATCH: begin
            sub_addr_d = rom_data_i[15:8];
            data_d     = rom_data_i[7:0];
            if (rom_data_i[15:8] == DELAY_TAG) begin
               state_d = S_DELAY;
               dly_d   = {rom_data_i[7:0], 8'h00};
            end else begin
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
            to_d    = TO_LOAD;
         end

         // ready_i may still be high from the previous transfer; only its fall
         // shows that the writer took the request.
         S_WAIT_BUSY: begin
            if (!ready_i) begin
               state_d = S_WAIT_DONE;
               to_d    = TO_LOAD;
            end else if (to_q == '0) begin
               attempt_err = 1'b1;
            end else begin
               to_d = to_q - 1'b1;
            end
         end

         // ready_i is checked before the timeout so it wins a same-cycle tie.
         S_WAIT_DONE: begin
            if (ready_i) begin
               attempt_err = errory_i;
               attempt_ok  = !errory_i;
            end else if (to_q == '0) begin
               attempt_err = 1'b1;
            end else begin
               to_d = to_q - 1'b1;
            end
         end

         S_DELAY: begin
            if (dly_q == '0) begin
               attempt_ok = 1'b1;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end

         S_GAP: begin
            if (gap_q == '0) begin
               state_d = gap_to_issue_q ? S_ISSUE : S_FETCH;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Success: advance to the next entry, or finish after the last one.
      if (attempt_ok) begin
         retry_d = '0;
         if (rom_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
         end else begin
            rom_addr_d     = rom_addr_q + 1'b1;
            gap_to_issue_d = 1'b0;
            gap_d          = GAP_LOAD;
            state_d        = (GAP_CYCLES > 0) ? S_GAP : S_FETCH;
         end
      end

      // Error: re-issue the latched entry without re-reading the ROM, or give up.
      if (attempt_err) begin
         if (retry_q < RETRY_MAX) begin
            retry_d        = retry_q + 1'b1;
            gap_to_issue_d = 1'b1;
            gap_d          = GAP_LOAD;
            state_d        = (GAP_CYCLES > 0) ? S_GAP : S_ISSUE;
         end else begin
            err_index_d = rom_addr_q;
            state_d     = S_FAIL;
         end
      end

      // Status outputs are registered copies decoded from the next state.
      write_d = (state_d == S_ISSUE);
      busy_d  = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
      done_d  = (state_d == S_DONE);
      fail_d  = (state_d == S_FAIL);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         rom_addr_q     <= '0;
         sub_addr_q     <= '0;
         data_q         <= '0;
         write_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         fail_q         <= 1'b0;
         err_index_q    <= '0;
         retry_q        <= '0;
         to_q           <= '0;
         dly_q          <= '0;
         gap_q          <= '0;
         gap_to_issue_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rom_addr_q     <= rom_addr_d;
         sub_addr_q     <= sub_addr_d;
         data_q         <= data_d;
         write_q        <= write_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         fail_q         <= fail_d;
         err_index_q    <= err_index_d;
         retry_q        <= retry_d;
         to_q           <= to_d;
         dly_q          <= dly_d;
         gap_q          <= gap_d;
         gap_to_issue_q <= gap_to_issue_d;
      end
   end

   assign rom_addr_o   = rom_addr_q;
   assign sub_addr_l_o = sub_addr_q;
   assign data_o       = data_q;
   assign write_o      = write_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign fail_o       = fail_q;
   assign err_index_o  = err_index_q;

endmodule

// File: tb/tb_de_coder_config_seq.sv
// -----------------------------------------------------------------------------
// tb_de_coder_config_seq
//
// Directed bench for de_coder_config_seq with a 4-entry table, a synchronous
// ROM model and a writer model that holds ready low for ACK_LOW cycles per
// accepted write. The writer answers errory=1 to the first budget[idx]
// attempts of entry idx, or never drops ready at all when never_ack is set.
//
// Write timing used for the spacing checks (s = edge that enters ISSUE):
//   s+1 WAIT_BUSY, writer drops ready; s+2 WAIT_DONE; ready rises at s+21;
//   completion edge s+22. GAP lasts GAP_CYCLES cycles, then FETCH, LATCH,
//   ISSUE: next entry issues at s+24+G, a retry at s+22+G.
//   Timeout with ready stuck high: error at s+1+TIMEOUT, retry at s+1+T+G.
//   Delay entry data=2 between two writes: DELAY lasts 513 cycles, so the
//   next write is at s+24+G+513+G+2 = s+539+2G.
// -----------------------------------------------------------------------------
module tb_de_coder_config_seq;

   localparam int N_REGS     = 4;
   localparam int ADDR_W     = 2;
   localparam int MAX_RETRY  = 3;
   localparam int TIMEOUT    = 40;
   localparam int GAP_CYCLES = 4;
   localparam int ACK_LOW    = 20;

   logic              clk_i   = 1'b0;
   logic              rst_i   = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [15:0]       rom_data_i;
   logic [7:0]        sub_addr_l_o;
   logic [7:0]        data_o;
   logic              write_o;
   logic              ready_i;
   logic              errory_i;
   logic              busy_o;
   logic              done_o;
   logic              fail_o;
   logic [ADDR_W-1:0] err_index_o;

   de_coder_config_seq #(
      .N_REGS    (N_REGS),
      .ADDR_W    (ADDR_W),
      .MAX_RETRY (MAX_RETRY),
      .TIMEOUT   (TIMEOUT),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .rom_addr_o  (rom_addr_o),
      .rom_data_i  (rom_data_i),
      .sub_addr_l_o(sub_addr_l_o),
      .data_o      (data_o),
      .write_o     (write_o),
      .ready_i     (ready_i),
      .errory_i    (errory_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .fail_o      (fail_o),
      .err_index_o (err_index_o)
   );

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   logic [15:0] rom    [N_REGS];
   logic [7:0]  budget [N_REGS];
   logic [7:0]  given  [N_REGS];
   logic        never_ack = 1'b0;
   logic        pend_err;
   int          ack_cnt;

   typedef struct {
      logic [ADDR_W-1:0] idx;
      logic [7:0]        sub;
      logic [7:0]        dat;
      int                stamp;
   } wr_t;

   wr_t wr_q[$];
   wr_t mon_w;

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Synchronous table ROM.
   always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

   // Writer model.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_i  <= 1'b1;
         errory_i <= 1'b0;
         ack_cnt  <= 0;
         pend_err <= 1'b0;
         for (int i = 0; i < N_REGS; i++) given[i] <= '0;
      end else if (write_o) begin
         if (!never_ack) begin
            ready_i <= 1'b0;
            ack_cnt <= ACK_LOW;
            pend_err <= (given[rom_addr_o] < budget[rom_addr_o]);
            if (given[rom_addr_o] < budget[rom_addr_o])
               given[rom_addr_o] <= given[rom_addr_o] + 8'd1;
         end
      end else if (ack_cnt != 0) begin
         ack_cnt <= ack_cnt - 1;
         if (ack_cnt == 1) begin
            ready_i  <= 1'b1;
            errory_i <= pend_err;
         end
      end
   end

   // Write monitor: one record per cycle with write high.
   always @(negedge clk_i) begin
      if (write_o) begin
         mon_w.idx   = rom_addr_o;
         mon_w.sub   = sub_addr_l_o;
         mon_w.dat   = data_o;
         mon_w.stamp = cyc;
         wr_q.push_back(mon_w);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   task automatic set_budget(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
      budget[0] = a; budget[1] = b; budget[2] = c; budget[3] = d;
   endtask

   // Called at a negedge; returns at the negedge after the sampling edge E0,
   // with t0 = cycle stamp of E0.
   task automatic pulse_start(output int t0);
      start_i = 1'b1;
      @(negedge clk_i);
      t0 = cyc;
      start_i = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int max_cyc);
      int n = 0;
      while (!(done_o || fail_o) && n < max_cyc) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_terminates"}, 32'(done_o || fail_o), 32'd1);
   endtask

   // seq holds the expected entry index of write k in nibble k (LSB first).
   task automatic check_seq(input string tag, input int base, input int cnt,
                            input logic [31:0] seq);
      int got_n = wr_q.size() - base;
      check({tag, "_nwrites"}, 32'(got_n), 32'(cnt));
      for (int k = 0; k < cnt && k < got_n; k++) begin
         logic [3:0] ei;
         ei = seq[4*k +: 4];
         check($sformatf("%s_w%0d_idx", tag, k), 32'(wr_q[base+k].idx), 32'(ei));
         check($sformatf("%s_w%0d_sub", tag, k), 32'(wr_q[base+k].sub), 32'(rom[ei[1:0]][15:8]));
         check($sformatf("%s_w%0d_dat", tag, k), 32'(wr_q[base+k].dat), 32'(rom[ei[1:0]][7:0]));
      end
   endtask

   function automatic int stamp_diff(input int base, input int a, input int b);
      if (wr_q.size() > base + b) return wr_q[base+b].stamp - wr_q[base+a].stamp;
      return -1;
   endfunction

   initial begin
      int t0;
      int base;
      int n;

      load_rom(16'h0004, 16'h030C, 16'h1D47, 16'h3102);
      set_budget(0, 0, 0, 0);
      #1 rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);

      // Reset values.
      check("rst_write",     32'(write_o),      32'd0);
      check("rst_busy",      32'(busy_o),       32'd0);
      check("rst_done",      32'(done_o),       32'd0);
      check("rst_fail",      32'(fail_o),       32'd0);
      check("rst_rom_addr",  32'(rom_addr_o),   32'd0);
      check("rst_sub",       32'(sub_addr_l_o), 32'd0);
      check("rst_data",      32'(data_o),       32'd0);
      check("rst_err_index", 32'(err_index_o),  32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // 1: clean sequence; a start while busy is ignored.
      base = wr_q.size();
      pulse_start(t0);
      check("t1_busy_after_start", 32'(busy_o), 32'd1);
      repeat (10) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_end("t1", 1000);
      check_seq("t1", base, 4, 32'h3210);
      if (wr_q.size() > base)
         check("t1_start_latency", 32'(wr_q[base].stamp - t0), 32'd2);
      check("t1_entry_spacing", 32'(stamp_diff(base, 0, 1)), 32'(24 + GAP_CYCLES));
      check("t1_done", 32'(done_o), 32'd1);
      check("t1_busy", 32'(busy_o), 32'd0);
      check("t1_fail", 32'(fail_o), 32'd0);

      // 2: entry 1 fails twice, then passes.
      set_budget(0, 2, 0, 0);
      base = wr_q.size();
      pulse_start(t0);
      check("t2_done_cleared", 32'(done_o), 32'd0);
      wait_end("t2", 2000);
      check_seq("t2", base, 6, 32'h0032_1110);
      check("t2_retry_spacing", 32'(stamp_diff(base, 1, 2)), 32'(22 + GAP_CYCLES));
      check("t2_done", 32'(done_o), 32'd1);
      check("t2_fail", 32'(fail_o), 32'd0);

      // 3: entry 2 always fails.
      set_budget(0, 0, 8'hFF, 0);
      base = wr_q.size();
      pulse_start(t0);
      wait_end("t3", 2000);
      repeat (5) @(negedge clk_i);
      check_seq("t3", base, 6, 32'h0022_2210);
      check("t3_fail",      32'(fail_o),      32'd1);
      check("t3_err_index", 32'(err_index_o), 32'd2);
      check("t3_done",      32'(done_o),      32'd0);
      check("t3_busy",      32'(busy_o),      32'd0);

      // 4: writer never drops ready; every attempt times out.
      set_budget(0, 0, 0, 0);
      never_ack = 1'b1;
      base = wr_q.size();
      pulse_start(t0);
      check("t4_err_index_cleared", 32'(err_index_o), 32'd0);
      check("t4_fail_cleared",      32'(fail_o),      32'd0);
      wait_end("t4", 2000);
      check_seq("t4", base, 4, 32'h0000_0000);
      check("t4_timeout_spacing", 32'(stamp_diff(base, 0, 1)), 32'(TIMEOUT + 1 + GAP_CYCLES));
      check("t4_fail",      32'(fail_o),      32'd1);
      check("t4_err_index", 32'(err_index_o), 32'd0);
      never_ack = 1'b0;

      // 5: delay entry between two writes.
      load_rom(16'h0004, 16'hFF02, 16'h1D47, 16'h3102);
      base = wr_q.size();
      pulse_start(t0);
      wait_end("t5", 3000);
      check_seq("t5", base, 3, 32'h0000_0320);
      check("t5_delay_spacing", 32'(stamp_diff(base, 0, 1)), 32'(539 + 2 * GAP_CYCLES));
      check("t5_delay_min", 32'(stamp_diff(base, 0, 1) >= 512 + GAP_CYCLES + 3), 32'd1);
      check("t5_done", 32'(done_o), 32'd1);

      // 6: asynchronous reset in WAIT_DONE of entry 1, then a fresh start.
      load_rom(16'h0004, 16'h030C, 16'h1D47, 16'h3102);
      base = wr_q.size();
      pulse_start(t0);
      n = 0;
      while (wr_q.size() < base + 2 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check("t6_second_write_seen", 32'(wr_q.size() >= base + 2), 32'd1);
      repeat (5) @(negedge clk_i);
      check("t6_pre_rst_rom_addr", 32'(rom_addr_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      check("t6_rst_write",    32'(write_o),      32'd0);
      check("t6_rst_busy",     32'(busy_o),       32'd0);
      check("t6_rst_rom_addr", 32'(rom_addr_o),   32'd0);
      check("t6_rst_sub",      32'(sub_addr_l_o), 32'd0);
      check("t6_rst_data",     32'(data_o),       32'd0);
      check("t6_rst_done",     32'(done_o),       32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      base = wr_q.size();
      pulse_start(t0);
      wait_end("t6", 1000);
      check_seq("t6", base, 4, 32'h3210);
      if (wr_q.size() > base)
         check("t6_start_latency", 32'(wr_q[base].stamp - t0), 32'd2);
      check("t6_done", 32'(done_o), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
